// File: rtl/dm_access_seq.sv
// Data-memory access sequencer: turns core load/store requests into word-only memory
// transactions, with read-modify-write for sub-word stores, load extraction and a per-transaction timeout.
module dm_access_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_dmtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [16:0] LP_TMO = 17'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [2:0]  r_dmtype;
    logic [31:0] r_addr;
    logic [15:0] r_sdata;
    logic [31:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [15:0] r_cnt;

    logic        w_illegal;
    logic        w_word_store;
    logic        w_tmo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;

    // Request legality is judged on the live inputs; it only matters in IDLE.
    always_comb begin
        w_illegal = 1'b0;
        if (req_dmtype > 3'b100)
            w_illegal = 1'b1;
        if (req_we && (req_dmtype == 3'b010 || req_dmtype == 3'b100))
            w_illegal = 1'b1;
        if ((req_dmtype == 3'b001 || req_dmtype == 3'b010) && req_addr[0])
            w_illegal = 1'b1;
        if (req_dmtype == 3'b000 && req_addr[1:0] != 2'b00)
            w_illegal = 1'b1;
    end

    assign w_word_store = req_we && (req_dmtype == 3'b000);
    assign w_tmo        = ((17'(r_cnt) + 17'd1) == LP_TMO) && !mem_ack;

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_dmtype)
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = {16'h0000, w_half};
            3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        if (r_dmtype == 3'b011) begin
            w_mask = 32'h0000_00ff << {r_addr[1:0], 3'b000};
            w_ins  = {24'h000000, r_sdata[7:0]} << {r_addr[1:0], 3'b000};
        end else begin
            w_mask = 32'h0000_ffff << {r_addr[1], 4'b0000};
            w_ins  = {16'h0000, r_sdata} << {r_addr[1], 4'b0000};
        end
        w_merged = (r_word & ~w_mask) | (w_ins & w_mask);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal)
                        w_state_nxt = S_FIN;
                    else if (w_word_store)
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (mem_ack)
                    w_state_nxt = r_we ? S_MERGE : S_FIN;
                else if (w_tmo)
                    w_state_nxt = S_FIN;
            end
            S_MERGE: w_state_nxt = S_WR;
            S_WR: begin
                if (mem_ack || w_tmo)
                    w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_dmtype <= 3'b000;
            r_addr   <= 32'h0;
            r_sdata  <= 16'h0;
            r_word   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_cnt    <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_dmtype <= req_dmtype;
                        r_addr   <= req_addr;
                        r_sdata  <= req_wdata[15:0];
                        r_cnt    <= 16'h0;
                        r_err    <= w_illegal;
                        if (w_word_store)
                            r_wdata <= req_wdata;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_word <= mem_rdata;
                        if (!r_we)
                            r_rdata <= w_load;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_tmo)
                            r_err <= 1'b1;
                    end
                end
                S_MERGE: begin
                    r_wdata <= w_merged;
                    r_cnt   <= 16'h0;
                end
                S_WR: begin
                    if (!mem_ack) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_tmo)
                            r_err <= 1'b1;
                    end
                end
                S_FIN: begin
                    // err/rdata are only meaningful during the done pulse.
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    assign done      = (r_state == S_FIN);
    assign stall     = req_valid && !done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = (r_state == S_RD) || (r_state == S_WR);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dm_access_seq.sv
// Bench for dm_access_seq: randomized requests against a latency-programmable memory,
// checked against a transaction-level model of timing, memory traffic and results.
module tb_dm_access_seq;

    localparam int TMO = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dm_access_seq #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_dmtype(req_dmtype),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_arr   [256];
    logic [31:0] model_mem [256];
    int          lat_q[$];
    op_t         exp_ops[$];
    int          n_txn;

    bit          active;
    int          t0;
    int          e_rel;
    logic        e_err;
    logic [31:0] e_rd;
    bit          got_done;
    int          last_rel;
    logic        last_err;
    logic [31:0] last_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_illegal(logic we, logic [2:0] dt, logic [31:0] a);
        if (dt > 3'd4) return 1'b1;
        if (we && (dt == 3'd2 || dt == 3'd4)) return 1'b1;
        if ((dt == 3'd1 || dt == 3'd2) && a[0]) return 1'b1;
        if (dt == 3'd0 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] extract(logic [31:0] w, logic [2:0] dt, logic [1:0] lane);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(lane))) & 32'hff;
        h = (w >> (16 * int'(lane[1]))) & 32'hffff;
        case (dt)
            3'd1:    return b[0] === 1'bx ? 32'h0 : (h[15] ? (h | 32'hffff_0000) : h);
            3'd2:    return h;
            3'd3:    return b[7] ? (b | 32'hffff_ff00) : b;
            3'd4:    return b;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(logic [31:0] w, logic [2:0] dt, logic [1:0] lane, logic [31:0] wd);
        logic [31:0] m;
        int          sh;
        if (dt == 3'd3) begin
            sh = 8 * int'(lane);
            m  = 32'hff << sh;
        end else begin
            sh = 16 * int'(lane[1]);
            m  = 32'hffff << sh;
        end
        return (w & ~m) | ((wd << sh) & m);
    endfunction

    // Memory: answers the n-th cycle of a transaction where n-1 is the queued latency.
    int   r_cnt_m;
    int   cur_lat;
    bit   in_txn = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                r_cnt_m = 0;
                cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                n_txn++;
            end else begin
                r_cnt_m++;
            end
            if (r_cnt_m == cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr[9:2]] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_arr[mem_addr[9:2]];
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            in_txn    = 1'b0;
            mem_ack   = ($urandom % 4) == 0;
            mem_rdata = $urandom;
        end
    end

    // Compare process: every cycle, away from the active edge.
    logic        prev_req = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    always @(negedge clk) begin
        int   rel;
        logic exp_done;
        op_t  e;
        rel      = cyc - t0;
        exp_done = active && (rel == e_rel);
        chk("done", {31'h0, done}, {31'h0, exp_done});
        chk("stall", {31'h0, stall}, {31'h0, req_valid && !exp_done});
        if (done && active) begin
            chk("err", {31'h0, err}, {31'h0, e_err});
            chk("rdata", rdata, e_rd);
            chk("ops_left", exp_ops.size(), 0);
            got_done   = 1'b1;
            last_rel   = rel;
            last_err   = err;
            last_rdata = rdata;
        end
        if (mem_req && mem_ack) begin
            if (exp_ops.size() == 0) begin
                chk("unexpected_op", {31'h0, mem_we}, 32'hffff_ffff);
            end else begin
                e = exp_ops.pop_front();
                chk("op_we", {31'h0, mem_we}, {31'h0, e.we});
                chk("op_addr", mem_addr, e.addr);
                if (e.we) chk("op_wdata", mem_wdata, e.wdata);
            end
        end
        if (prev_req && mem_req) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_we", {31'h0, mem_we}, {31'h0, prev_we});
            chk("hold_wdata", mem_wdata, prev_wdata);
        end
        prev_req   = mem_req;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem_arr[a[9:2]]   = v;
        model_mem[a[9:2]] = v;
    endtask

    task automatic run_req(input logic we, input logic [2:0] dt, input logic [31:0] a,
                           input logic [31:0] wd, input int l1, input int l2);
        logic [31:0] wa;
        logic [31:0] mw;
        logic [7:0]  idx;
        @(posedge clk);
        #1;
        idx = a[9:2];
        wa  = {a[31:2], 2'b00};
        exp_ops.delete();
        lat_q.delete();
        e_err = 1'b0;
        e_rd  = 32'h0;
        if (is_illegal(we, dt, a)) begin
            e_rel = 1;
            e_err = 1'b1;
        end else if (!we || dt == 3'd0) begin
            lat_q.push_back(l1);
            if (l1 + 1 > TMO) begin
                e_rel = 1 + TMO;
                e_err = 1'b1;
            end else begin
                e_rel = l1 + 2;
                exp_ops.push_back({we, wa, we ? wd : 32'h0});
                if (we) model_mem[idx] = wd;
                else    e_rd = extract(model_mem[idx], dt, a[1:0]);
            end
        end else begin
            lat_q.push_back(l1);
            if (l1 + 1 > TMO) begin
                e_rel = 1 + TMO;
                e_err = 1'b1;
            end else begin
                exp_ops.push_back({1'b0, wa, 32'h0});
                lat_q.push_back(l2);
                mw = merge(model_mem[idx], dt, a[1:0], wd);
                if (l2 + 1 > TMO) begin
                    e_rel = 1 + (l1 + 1) + 1 + TMO;
                    e_err = 1'b1;
                end else begin
                    e_rel = 1 + (l1 + 1) + 1 + (l2 + 1);
                    exp_ops.push_back({1'b1, wa, mw});
                    model_mem[idx] = mw;
                end
            end
        end
        n_txn      = 0;
        got_done   = 1'b0;
        req_we     = we;
        req_dmtype = dt;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        t0         = cyc;
        active     = 1'b1;
        for (int i = 0; i < 40 && !got_done; i++) @(posedge clk);
        #1;
        if (!got_done) chk("done_timeout", 32'h0, 32'h1);
        req_valid = 1'b0;
        active    = 1'b0;
    endtask

    initial begin
        logic        we;
        logic [2:0]  dt;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; active = 1'b0; t0 = 0; e_rel = 0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;

        // Directed cases with hand-computed results.
        preload(32'h100, 32'h80FF_1234);
        run_req(1'b0, 3'd3, 32'h103, 32'h0, 0, 0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_rel", last_rel, 2);
        chk("lb_txn", n_txn, 1);
        preload(32'h200, 32'h1111_2222);
        run_req(1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 0, 0);
        chk("sh_mem", mem_arr[8'h80], 32'hABCD_2222);
        chk("sh_rel", last_rel, 4);
        chk("sh_txn", n_txn, 2);
        run_req(1'b1, 3'd0, 32'h300, 32'hDEAD_BEEF, 0, 0);
        chk("sw_mem", mem_arr[8'hC0], 32'hDEAD_BEEF);
        chk("sw_rel", last_rel, 2);
        chk("sw_txn", n_txn, 1);
        run_req(1'b0, 3'd0, 32'h102, 32'h0, 0, 0);
        chk("lw_mis_err", {31'h0, last_err}, 32'h1);
        chk("lw_mis_rel", last_rel, 1);
        chk("lw_mis_txn", n_txn, 0);
        preload(32'h120, 32'h9876_5432);
        run_req(1'b0, 3'd2, 32'h122, 32'h0, 9, 0);
        chk("lhu_tmo_err", {31'h0, last_err}, 32'h1);
        chk("lhu_tmo_rel", last_rel, 5);
        run_req(1'b0, 3'd2, 32'h122, 32'h0, 3, 0);
        chk("lhu_ack4_err", {31'h0, last_err}, 32'h0);
        chk("lhu_ack4_rel", last_rel, 5);
        chk("lhu_ack4_rdata", last_rdata, 32'h0000_9876);

        // Reset while WR is being acknowledged: no done, bus idle next cycle.
        @(posedge clk);
        #1;
        exp_ops.delete();
        lat_q.delete();
        lat_q.push_back(0);
        exp_ops.push_back({1'b1, 32'h340, 32'h5A5A_0F0F});
        model_mem[8'hD0] = 32'h5A5A_0F0F;
        req_we = 1'b1; req_dmtype = 3'd0; req_addr = 32'h340; req_wdata = 32'h5A5A_0F0F;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwr_in_wr", {31'h0, mem_req && mem_we}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        chk("rstwr_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rstwr_done", {31'h0, done}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstwr_ops", exp_ops.size(), 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            dt = ($urandom % 4 != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            a  = {22'h0, 10'($urandom)};
            if ($urandom % 3 != 0) begin
                if (dt == 3'd0) a[1:0] = 2'b00;
                if (dt == 3'd1 || dt == 3'd2) a[0] = 1'b0;
            end
            run_req(we, dt, a, $urandom,
                    ($urandom % 8 == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                    ($urandom % 8 == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3));
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++)
            if (mem_arr[i] !== model_mem[i]) chk("final_mem", mem_arr[i], model_mem[i]);
        chk("final_ops", exp_ops.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
